// File: rtl/pic8259_pkg.sv
`default_nettype none
// pic8259_pkg: shared FSM state encoding and command-word bit positions for the 8259A model.
package pic8259_pkg;

  typedef enum logic [1:0] {
    CMD_READY = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } cwd_state_e;

  // A0=0 writes: D4 selects ICW1, otherwise D3 separates OCW2 (0) from OCW3 (1)
  localparam int ICW1_SEL_BIT  = 4;
  localparam int OCW_SEL_BIT   = 3;

  localparam int ICW1_IC4_BIT  = 0;
  localparam int ICW1_SNGL_BIT = 1;
  localparam int ICW1_LTIM_BIT = 3;

  localparam int ICW4_AEOI_BIT = 1;
  localparam int ICW4_SFNM_BIT = 4;

  localparam int OCW2_R_BIT    = 7;
  localparam int OCW2_SL_BIT   = 6;
  localparam int OCW2_EOI_BIT  = 5;
  localparam int OCW2_L2_BIT   = 2;
  localparam int OCW2_L1_BIT   = 1;
  localparam int OCW2_L0_BIT   = 0;

  localparam int OCW3_RIS_BIT  = 0;
  localparam int OCW3_RR_BIT   = 1;
  localparam int OCW3_P_BIT    = 2;
  localparam int OCW3_SMM_BIT  = 5;
  localparam int OCW3_ESMM_BIT = 6;

endpackage
`default_nettype wire

// File: rtl/write_strobe_detect.sv
`default_nettype none
// write_strobe_detect: captures A0/data during an active strobe and emits a one-cycle commit
// pulse after the strobe ends. Used for both the write and the read side of the bus.
module write_strobe_detect #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  chip_select_n_i,
  input  logic                  strobe_n_i,
  input  logic                  conflict_n_i,
  input  logic                  address_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  address_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  commit_o
);

  logic                  w_active;
  logic                  active_q;
  logic                  active_prev_q;
  logic                  address_q;
  logic [DATA_WIDTH-1:0] data_q;

  // A cycle with the opposite strobe also low is illegal and counts as inactive
  assign w_active = ~chip_select_n_i & ~strobe_n_i & conflict_n_i;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q      <= 1'b0;
      active_prev_q <= 1'b0;
      address_q     <= 1'b0;
      data_q        <= '0;
    end else begin
      active_q      <= w_active;
      active_prev_q <= active_q;
      if (w_active) begin
        address_q <= address_i;
        data_q    <= data_i;
      end
    end
  end

  assign commit_o  = active_prev_q & ~active_q;
  assign address_o = address_q;
  assign data_o    = data_q;

endmodule
`default_nettype wire

// File: rtl/command_word_decoder.sv
`default_nettype none
// command_word_decoder: decodes 8259A ICW1-ICW4 / OCW1-OCW3 CPU writes into configuration state.
// Optional macro CWD_POLL_COMMAND_EN enables the OCW3 poll command (poll_command tied 0 otherwise).
module command_word_decoder
  import pic8259_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  chip_select_n,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic                  address,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic                  init_done,
  output logic                  level_or_edge_triggered,
  output logic                  single_mode,
  output logic [4:0]            vector_address,
  output logic [7:0]            cascade_config,
  output logic                  auto_eoi,
  output logic [1:0]            buffered_mode,
  output logic                  special_fully_nested,
  output logic [7:0]            interrupt_mask,
  output logic                  eoi_pulse,
  output logic [5:0]            eoi_command,
  output logic                  enable_read_register,
  output logic                  read_register_isr_or_irr,
  output logic                  special_mask_mode,
  output logic                  poll_command
);

  cwd_state_e state_q, state_d;

  logic                  w_commit;
  logic                  w_a0;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_icw1, w_icw2, w_icw3, w_icw4;
  logic                  w_ocw1, w_ocw2, w_ocw3;
  logic                  w_init_finish;
  logic                  w_poll_set;

  logic       ic4_q, sngl_q, ltim_q, init_done_q;
  logic [4:0] vector_q;
  logic [7:0] cascade_q;
  logic       aeoi_q, sfnm_q;
  logic [1:0] buf_q;
  logic [7:0] mask_q;
  logic       eoi_pulse_q;
  logic [5:0] eoi_cmd_q;
  logic       rr_q, ris_q, smm_q;

  write_strobe_detect #(.DATA_WIDTH(DATA_WIDTH)) u_write_strobe (
    .clock           (clock),
    .reset_n         (reset_n),
    .chip_select_n_i (chip_select_n),
    .strobe_n_i      (write_n),
    .conflict_n_i    (read_n),
    .address_i       (address),
    .data_i          (data_bus_in),
    .address_o       (w_a0),
    .data_o          (w_data),
    .commit_o        (w_commit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= CMD_READY;
    else          state_q <= state_d;
  end

  // ICW1 wins in every state; A0=0 non-ICW1 writes fall through and are dropped in WAIT_* states
  always_comb begin
    w_icw1 = 1'b0;
    w_icw2 = 1'b0;
    w_icw3 = 1'b0;
    w_icw4 = 1'b0;
    w_ocw1 = 1'b0;
    w_ocw2 = 1'b0;
    w_ocw3 = 1'b0;
    if (w_commit) begin
      if (!w_a0 && w_data[ICW1_SEL_BIT]) begin
        w_icw1 = 1'b1;
      end else if (w_a0 && state_q == WAIT_ICW2) begin
        w_icw2 = 1'b1;
      end else if (w_a0 && state_q == WAIT_ICW3) begin
        w_icw3 = 1'b1;
      end else if (w_a0 && state_q == WAIT_ICW4) begin
        w_icw4 = 1'b1;
      end else if (state_q == CMD_READY && init_done_q) begin
        if (w_a0)                        w_ocw1 = 1'b1;
        else if (!w_data[OCW_SEL_BIT])   w_ocw2 = 1'b1;
        else                             w_ocw3 = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_icw1)      state_d = WAIT_ICW2;
    else if (w_icw2) state_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : CMD_READY);
    else if (w_icw3) state_d = ic4_q ? WAIT_ICW4 : CMD_READY;
    else if (w_icw4) state_d = CMD_READY;
  end

  assign w_init_finish = (w_icw2 & sngl_q & ~ic4_q) | (w_icw3 & ~ic4_q) | w_icw4;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ic4_q       <= 1'b0;
      sngl_q      <= 1'b0;
      ltim_q      <= 1'b0;
      init_done_q <= 1'b0;
      vector_q    <= '0;
      cascade_q   <= '0;
      aeoi_q      <= 1'b0;
      buf_q       <= '0;
      sfnm_q      <= 1'b0;
      mask_q      <= '0;
      eoi_pulse_q <= 1'b0;
      eoi_cmd_q   <= '0;
      rr_q        <= 1'b1;
      ris_q       <= 1'b0;
      smm_q       <= 1'b0;
    end else begin
      eoi_pulse_q <= w_ocw2;
      if (w_icw1) begin
        ic4_q       <= w_data[ICW1_IC4_BIT];
        sngl_q      <= w_data[ICW1_SNGL_BIT];
        ltim_q      <= w_data[ICW1_LTIM_BIT];
        mask_q      <= '0;
        smm_q       <= 1'b0;
        rr_q        <= 1'b1;
        ris_q       <= 1'b0;
        init_done_q <= 1'b0;
        aeoi_q      <= 1'b0;
      end
      if (w_init_finish) init_done_q <= 1'b1;
      if (w_icw2) vector_q  <= w_data[7:3];
      if (w_icw3) cascade_q <= w_data[7:0];
      if (w_icw4) begin
        aeoi_q <= w_data[ICW4_AEOI_BIT];
        buf_q  <= w_data[3:2];
        sfnm_q <= w_data[ICW4_SFNM_BIT];
      end
      if (w_ocw1) mask_q <= w_data[7:0];
      if (w_ocw2) begin
        eoi_cmd_q <= {w_data[OCW2_R_BIT], w_data[OCW2_SL_BIT], w_data[OCW2_EOI_BIT],
                      w_data[OCW2_L2_BIT], w_data[OCW2_L1_BIT], w_data[OCW2_L0_BIT]};
      end
      if (w_ocw3) begin
        if (w_data[OCW3_RR_BIT] && !w_poll_set) begin
          rr_q  <= 1'b1;
          ris_q <= w_data[OCW3_RIS_BIT];
        end
        if (w_data[OCW3_ESMM_BIT]) smm_q <= w_data[OCW3_SMM_BIT];
      end
    end
  end

`ifdef CWD_POLL_COMMAND_EN
  logic                  w_rd_commit;
  logic                  w_rd_a0;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  poll_q;

  write_strobe_detect #(.DATA_WIDTH(DATA_WIDTH)) u_read_strobe (
    .clock           (clock),
    .reset_n         (reset_n),
    .chip_select_n_i (chip_select_n),
    .strobe_n_i      (read_n),
    .conflict_n_i    (write_n),
    .address_i       (address),
    .data_i          (data_bus_in),
    .address_o       (w_rd_a0),
    .data_o          (w_rd_data),
    .commit_o        (w_rd_commit)
  );

  assign w_poll_set = w_ocw3 & w_data[OCW3_P_BIT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         poll_q <= 1'b0;
    else if (w_poll_set)  poll_q <= 1'b1;
    else if (w_rd_commit) poll_q <= 1'b0;
  end

  assign poll_command = poll_q;
`else
  assign w_poll_set   = 1'b0;
  assign poll_command = 1'b0;
`endif

  assign init_done                = init_done_q;
  assign level_or_edge_triggered  = ltim_q;
  assign single_mode              = sngl_q;
  assign vector_address           = vector_q;
  assign cascade_config           = cascade_q;
  assign auto_eoi                 = aeoi_q;
  assign buffered_mode            = buf_q;
  assign special_fully_nested     = sfnm_q;
  assign interrupt_mask           = mask_q;
  assign eoi_pulse                = eoi_pulse_q;
  assign eoi_command              = eoi_cmd_q;
  assign enable_read_register     = rr_q;
  assign read_register_isr_or_irr = ris_q;
  assign special_mask_mode        = smm_q;

endmodule
`default_nettype wire

// File: tb/tb_command_word_decoder.sv
`default_nettype none
// tb_command_word_decoder: scoreboard bench; each CPU write pushes the expected register snapshot.
module tb_command_word_decoder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       chip_select_n, write_n, read_n, address;
  logic [7:0] data_bus_in;
  logic       init_done, level_or_edge_triggered, single_mode, auto_eoi;
  logic       special_fully_nested, eoi_pulse, enable_read_register;
  logic       read_register_isr_or_irr, special_mask_mode, poll_command;
  logic [4:0] vector_address;
  logic [7:0] cascade_config, interrupt_mask;
  logic [1:0] buffered_mode;
  logic [5:0] eoi_command;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] RESET_SNAP = 32'h0000_0008;
  localparam int S_RDY = 0, S_W2 = 1, S_W3 = 2, S_W4 = 3;

  logic [31:0] sb[$];
  logic [5:0]  eoi_sb[$];

  int         m_state;
  logic       m_ic4, m_sngl, m_ltim, m_init, m_aeoi, m_sfnm, m_rr, m_ris, m_smm, m_poll;
  logic [4:0] m_vec;
  logic [7:0] m_cas, m_mask;
  logic [1:0] m_buf;

  command_word_decoder #(.DATA_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .chip_select_n(chip_select_n), .write_n(write_n),
    .read_n(read_n), .address(address), .data_bus_in(data_bus_in), .init_done(init_done),
    .level_or_edge_triggered(level_or_edge_triggered), .single_mode(single_mode),
    .vector_address(vector_address), .cascade_config(cascade_config), .auto_eoi(auto_eoi),
    .buffered_mode(buffered_mode), .special_fully_nested(special_fully_nested),
    .interrupt_mask(interrupt_mask), .eoi_pulse(eoi_pulse), .eoi_command(eoi_command),
    .enable_read_register(enable_read_register),
    .read_register_isr_or_irr(read_register_isr_or_irr),
    .special_mask_mode(special_mask_mode), .poll_command(poll_command)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dut_snap();
    return {init_done, level_or_edge_triggered, single_mode, vector_address, cascade_config,
            auto_eoi, buffered_mode, special_fully_nested, interrupt_mask,
            enable_read_register, read_register_isr_or_irr, special_mask_mode, poll_command};
  endfunction

  function automatic logic [31:0] model_snap();
    return {m_init, m_ltim, m_sngl, m_vec, m_cas, m_aeoi, m_buf, m_sfnm, m_mask,
            m_rr, m_ris, m_smm, m_poll};
  endfunction

  task automatic model_reset();
    m_state = S_RDY; m_ic4 = 0; m_sngl = 0; m_ltim = 0; m_init = 0; m_aeoi = 0; m_sfnm = 0;
    m_rr = 1; m_ris = 0; m_smm = 0; m_poll = 0; m_vec = '0; m_cas = '0; m_mask = '0; m_buf = '0;
    sb.delete();
    eoi_sb.delete();
  endtask

  // Reference behaviour of one committed CPU write
  task automatic model_write(input logic a0, input logic [7:0] d);
    logic p;
    if (!a0 && d[4]) begin
      m_ic4 = d[0]; m_sngl = d[1]; m_ltim = d[3]; m_mask = 8'h00; m_smm = 0;
      m_rr = 1; m_ris = 0; m_init = 0; m_aeoi = 0; m_state = S_W2;
    end else if (a0 && m_state == S_W2) begin
      m_vec = d[7:3];
      if (!m_sngl)    m_state = S_W3;
      else if (m_ic4) m_state = S_W4;
      else begin m_state = S_RDY; m_init = 1; end
    end else if (a0 && m_state == S_W3) begin
      m_cas = d;
      if (m_ic4) m_state = S_W4;
      else begin m_state = S_RDY; m_init = 1; end
    end else if (a0 && m_state == S_W4) begin
      m_aeoi = d[1]; m_buf = d[3:2]; m_sfnm = d[4]; m_state = S_RDY; m_init = 1;
    end else if (m_state == S_RDY && m_init) begin
      if (a0) m_mask = d;
      else if (d[4:3] == 2'b00) eoi_sb.push_back({d[7:5], d[2:0]});
      else begin
`ifdef CWD_POLL_COMMAND_EN
        p = d[2];
        if (p) m_poll = 1;
`else
        p = 1'b0;
`endif
        if (d[1] && !p) begin m_rr = 1; m_ris = d[0]; end
        if (d[6]) m_smm = d[5];
      end
    end
  endtask

  // One-cycle write strobe; returns at the negedge where ~WR rises
  task automatic cpu_write(input logic a0, input logic [7:0] d);
    @(negedge clock);
    chip_select_n = 0; write_n = 0; address = a0; data_bus_in = d;
    @(negedge clock);
    chip_select_n = 1; write_n = 1;
    model_write(a0, d);
    sb.push_back(model_snap());
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 0;
    model_reset();
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_reset();
    logic [31:0] s;
    reset_n = 0; chip_select_n = 1; write_n = 1; read_n = 1; address = 0; data_bus_in = 0;
    model_reset();
    #12;
    s = dut_snap();
    checks++;
    if (s !== RESET_SNAP || eoi_pulse !== 1'b0 || eoi_command !== 6'd0) begin
      failures++;
      $display("FAIL reset_state: got snap=%h pulse=%b cmd=%b want snap=%h pulse=0 cmd=0",
               s, eoi_pulse, eoi_command, RESET_SNAP);
    end
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_single_init();
    logic [8:0] tbl[3] = '{{1'b0, 8'h13}, {1'b1, 8'h20}, {1'b1, 8'h01}};
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      cpu_write(tbl[i][8], tbl[i][7:0]);
      @(posedge clock); #1;
      if (i == 2) begin
        checks++;
        if (init_done !== 1'b0) begin
          failures++;
          $display("FAIL single_init_latency: init_done=%b one edge after ~WR rise, want 0", init_done);
        end
      end
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e) begin
        failures++;
        $display("FAIL single_init write %0d: got %h want %h", i, dut_snap(), e);
      end
    end
    checks++;
    if (vector_address !== 5'h04 || init_done !== 1'b1 || cascade_config !== 8'h00) begin
      failures++;
      $display("FAIL single_init_final: vec=%h done=%b cas=%h want 04 1 00",
               vector_address, init_done, cascade_config);
    end
  endtask

  task automatic test_cascade_init();
    logic [8:0] tbl[4] = '{{1'b0, 8'h11}, {1'b1, 8'h08}, {1'b1, 8'h04}, {1'b1, 8'h03}};
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      cpu_write(tbl[i][8], tbl[i][7:0]);
      repeat (2) @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e) begin
        failures++;
        $display("FAIL cascade_init write %0d: got %h want %h", i, dut_snap(), e);
      end
    end
    checks++;
    if (cascade_config !== 8'h04 || auto_eoi !== 1'b1 || init_done !== 1'b1 || vector_address !== 5'h01) begin
      failures++;
      $display("FAIL cascade_init_final: cas=%h aeoi=%b done=%b vec=%h want 04 1 1 01",
               cascade_config, auto_eoi, init_done, vector_address);
    end
  endtask

  task automatic test_ocw();
    logic [8:0] tbl[5] = '{{1'b1, 8'hAA}, {1'b0, 8'h0B}, {1'b0, 8'h0A}, {1'b0, 8'h68}, {1'b0, 8'h48}};
    logic [31:0] e;
    for (int i = 0; i < 5; i++) begin
      cpu_write(tbl[i][8], tbl[i][7:0]);
      repeat (2) @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e) begin
        failures++;
        $display("FAIL ocw write %0d: got %h want %h", i, dut_snap(), e);
      end
      if (i == 1) begin
        checks++;
        if (enable_read_register !== 1'b1 || read_register_isr_or_irr !== 1'b1) begin
          failures++;
          $display("FAIL ocw3_ris: rr=%b ris=%b want 1 1", enable_read_register, read_register_isr_or_irr);
        end
      end
    end
    checks++;
    if (interrupt_mask !== 8'hAA || read_register_isr_or_irr !== 1'b0 || special_mask_mode !== 1'b0) begin
      failures++;
      $display("FAIL ocw_final: mask=%h ris=%b smm=%b want AA 0 0",
               interrupt_mask, read_register_isr_or_irr, special_mask_mode);
    end
  endtask

  task automatic test_ocw2();
    logic [31:0] e;
    logic [5:0]  ec;
    cpu_write(1'b0, 8'h65);
    @(posedge clock); #1;
    checks++;
    if (eoi_pulse !== 1'b0) begin
      failures++;
      $display("FAIL ocw2_early: eoi_pulse=%b before commit edge, want 0", eoi_pulse);
    end
    @(posedge clock); #1;
    e = sb.pop_front();
    ec = (eoi_sb.size() > 0) ? eoi_sb.pop_front() : 6'bx;
    checks++;
    if (eoi_pulse !== 1'b1 || eoi_command !== ec || ec !== 6'b011101 || dut_snap() !== e) begin
      failures++;
      $display("FAIL ocw2_pulse: pulse=%b cmd=%b snap=%h want 1 %b %h", eoi_pulse, eoi_command, dut_snap(), ec, e);
    end
    @(posedge clock); #1;
    checks++;
    if (eoi_pulse !== 1'b0 || eoi_command !== 6'b011101) begin
      failures++;
      $display("FAIL ocw2_width: pulse=%b cmd=%b a cycle later, want 0 011101", eoi_pulse, eoi_command);
    end
  endtask

  task automatic test_pre_init();
    logic [8:0] tbl[9] = '{{1'b1, 8'h55}, {1'b0, 8'h13}, {1'b0, 8'h0B}, {1'b1, 8'h20},
                           {1'b1, 8'hFF}, {1'b0, 8'h11}, {1'b1, 8'h08}, {1'b0, 8'h11},
                           {1'b1, 8'h10}};
    logic [31:0] e;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        // complete the first init by hand so the mask can be set before ICW1 clears it
        cpu_write(1'b1, 8'h00);
        repeat (2) @(posedge clock);
        void'(sb.pop_front());
      end
      cpu_write(tbl[i][8], tbl[i][7:0]);
      repeat (2) @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e) begin
        failures++;
        $display("FAIL pre_init write %0d: got %h want %h", i, dut_snap(), e);
      end
      if (i == 0) begin
        checks++;
        if (interrupt_mask !== 8'h00) begin
          failures++;
          $display("FAIL ocw1_before_init: mask=%h want 00", interrupt_mask);
        end
      end
    end
    checks++;
    if (interrupt_mask !== 8'h00 || vector_address !== 5'h02 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL icw1_restart: mask=%h vec=%h done=%b want 00 02 0", interrupt_mask, vector_address, init_done);
    end
  endtask

  task automatic test_illegal_write();
    logic [31:0] e;
    e = model_snap();
    @(negedge clock);
    chip_select_n = 0; write_n = 0; read_n = 0; address = 1; data_bus_in = 8'h33;
    @(negedge clock);
    chip_select_n = 1; write_n = 1; read_n = 1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (dut_snap() !== e) begin
      failures++;
      $display("FAIL illegal_write: got %h want %h", dut_snap(), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    fork
      begin
        cpu_write(1'b1, 8'h11);
        cpu_write(1'b1, 8'h22);
        cpu_write(1'b1, 8'h33);
      end
      begin
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
          repeat (2) @(posedge clock);
          #1;
          e = (sb.size() > 0) ? sb.pop_front() : 32'hx;
          checks++;
          if (dut_snap() !== e) begin
            failures++;
            $display("FAIL back_to_back write %0d: got %h want %h", i, dut_snap(), e);
          end
        end
      end
    join
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (sb.size() != 0 || interrupt_mask !== 8'h33) begin
      failures++;
      $display("FAIL back_to_back_final: pending=%0d mask=%h want 0 33", sb.size(), interrupt_mask);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    cpu_write(1'b0, 8'h13);
    cpu_write(1'b1, 8'h40);
    repeat (2) @(posedge clock);
    #1;
    void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if (dut_snap() !== e) begin
      failures++;
      $display("FAIL enter_wait_icw4: got %h want %h", dut_snap(), e);
    end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (dut_snap() !== RESET_SNAP || eoi_pulse !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got %h pulse=%b want %h 0", dut_snap(), eoi_pulse, RESET_SNAP);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1;
    cpu_write(1'b1, 8'h04);
    repeat (2) @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    if (dut_snap() !== e || init_done !== 1'b0 || buffered_mode !== 2'b00) begin
      failures++;
      $display("FAIL after_reset_waits_icw1: got %h want %h", dut_snap(), e);
    end
  endtask

`ifdef CWD_POLL_COMMAND_EN
  task automatic test_poll();
    logic [8:0] tbl[4] = '{{1'b0, 8'h13}, {1'b1, 8'h20}, {1'b0, 8'h0C}, {1'b0, 8'h0F}};
    logic [31:0] e;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        cpu_write(1'b1, 8'h00);
        repeat (2) @(posedge clock);
        void'(sb.pop_front());
      end
      cpu_write(tbl[i][8], tbl[i][7:0]);
      repeat (2) @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e) begin
        failures++;
        $display("FAIL poll write %0d: got %h want %h", i, dut_snap(), e);
      end
    end
    checks++;
    if (poll_command !== 1'b1 || read_register_isr_or_irr !== 1'b0) begin
      failures++;
      $display("FAIL poll_set: poll=%b ris=%b want 1 0", poll_command, read_register_isr_or_irr);
    end
    @(negedge clock);
    chip_select_n = 0; read_n = 0;
    @(negedge clock);
    chip_select_n = 1; read_n = 1;
    m_poll = 0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (poll_command !== 1'b0 || dut_snap() !== model_snap()) begin
      failures++;
      $display("FAIL poll_clear: poll=%b snap=%h want 0 %h", poll_command, dut_snap(), model_snap());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_init();
    test_cascade_init();
    test_ocw();
    test_ocw2();
    test_illegal_write();
    test_back_to_back();
    test_pre_init();
    test_async_reset();
`ifdef CWD_POLL_COMMAND_EN
    test_poll();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/command_word_decoder.md
Name: command_word_decoder

Overview:
- Write-side control stage of the 8259A model; sits directly upstream of DataBusBuffer.
- Decodes CPU write cycles (~CS, ~WR, A0, D[7:0]) into ICW1–ICW4 and OCW1–OCW3.
- Holds the resulting configuration registers.
- Drives DataBusBuffer's status-read controls: interrupt_mask, enable_read_register, read_register_isr_or_irr.

Parameters:
- DATA_WIDTH, 8, CPU data bus width; only 8 is supported.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- chip_select_n  in  1  active-low chip select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe
- address  in  1  A0
- data_bus_in  in  8  CPU write data
- init_done  out  1  initialization sequence complete
- level_or_edge_triggered  out  1  ICW1 LTIM
- single_mode  out  1  ICW1 SNGL
- vector_address  out  5  ICW2 T7–T3
- cascade_config  out  8  ICW3 value
- auto_eoi  out  1  ICW4 AEOI
- buffered_mode  out  2  ICW4 BUF, M/S
- special_fully_nested  out  1  ICW4 SFNM
- interrupt_mask  out  8  OCW1 IMR
- eoi_pulse  out  1  one-cycle OCW2 command strobe
- eoi_command  out  6  {R, SL, EOI, L2, L1, L0} captured with eoi_pulse
- enable_read_register  out  1  OCW3 RR latched
- read_register_isr_or_irr  out  1  OCW3 RIS latched; 0 = IRR, 1 = ISR
- special_mask_mode  out  1  OCW3 SMM state
- poll_command  out  1  see Optional Feature

Behaviour:
- Inputs are synchronous to clock.
- write_active = ~chip_select_n & ~write_n.
  - address and data_bus_in are captured every cycle while write_active is 1.
  - A commit pulse is generated in the cycle where the registered write_active falls 1->0.
  - Outputs update on the clock edge following the commit pulse: one-cycle latency from deassertion of ~WR.
- write_active together with ~read_n low is illegal: that cycle is not captured, and no commit occurs for it.
- FSM states: CMD_READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4. Reset state is CMD_READY.
- ICW1 (A0=0, D4=1) is accepted in any state and restarts initialization. On commit:
  - latch IC4=D0, SNGL=D1, LTIM=D3;
  - interrupt_mask <= 00h, special_mask_mode <= 0;
  - enable_read_register <= 1, read_register_isr_or_irr <= 0 (IRR);
  - init_done <= 0, auto_eoi <= 0, next state WAIT_ICW2.
- WAIT_ICW2, A0=1: vector_address <= D7:3. Next state:
  - WAIT_ICW3 if SNGL=0;
  - else WAIT_ICW4 if IC4=1;
  - else CMD_READY with init_done <= 1.
- WAIT_ICW3, A0=1: cascade_config <= D. Next state is WAIT_ICW4 if IC4=1, else CMD_READY with init_done <= 1.
- WAIT_ICW4, A0=1: auto_eoi <= D1, buffered_mode <= D3:2, special_fully_nested <= D4. Next state CMD_READY, init_done <= 1.
- A0=0 non-ICW1 writes while in a WAIT_* state are ignored; the state is unchanged.
- In CMD_READY with init_done=1:
  - A0=1 -> OCW1: interrupt_mask <= D.
  - A0=0, D4:3=00 -> OCW2: eoi_command <= {D7, D6, D5, D2, D1, D0}, eoi_pulse high for exactly 1 cycle.
  - A0=0, D4:3=01 -> OCW3:
    - if D1=1: enable_read_register <= 1 and read_register_isr_or_irr <= D0; if D1=0 both are held;
    - if D6=1: special_mask_mode <= D5; if D6=0 it is held.
- All OCW writes before init_done=1 are ignored.
- Reset values:
  - FSM = CMD_READY;
  - all config outputs 0; interrupt_mask = 00h;
  - enable_read_register = 1, read_register_isr_or_irr = 0;
  - eoi_pulse = 0, poll_command = 0, init_done = 0.
- Reset asserted mid-sequence aborts the sequence immediately. After release, the block waits for ICW1.
- Back-to-back writes need at least one cycle of write_active=0 between them. Each deassertion yields exactly one commit.

Optional Feature:
- Macro: CWD_POLL_COMMAND_EN.
- Defined: an OCW3 write with D2=1 sets poll_command. It clears on the commit of the next read cycle (~CS & ~RD deasserting). While P=1, the RR/RIS bits of that same write are ignored.
- Undefined: D2 is ignored and poll_command is tied 0.

Decomposition:
- Shared package pic8259_pkg holds:
  - the FSM state enum;
  - the OCW2 field index constants;
  - the ICW1/OCW select bit positions (D4, D3).
- One sub-module, write_strobe_detect: captures address/data and produces the commit pulse. It is reusable for the read side.

Test Plan:
- Sequence ICW1=13h, ICW2=20h, ICW4=01h (single, IC4) -> vector_address=04h, state CMD_READY, init_done=1 one cycle after the final ~WR rise, FSM skips WAIT_ICW3.
- ICW1=11h, ICW2=08h, ICW3=04h, ICW4=03h -> cascade_config=04h, auto_eoi=1, init_done=1.
- After init: OCW1=AAh -> interrupt_mask=AAh; OCW3=0Bh -> enable_read_register=1, read_register_isr_or_irr=1; OCW3=0Ah -> read_register_isr_or_irr=0.
- OCW2=65h -> eoi_pulse high for exactly 1 cycle, eoi_command=6'b011101.
- OCW1=55h before init_done -> interrupt_mask stays 00h. ICW1 arriving during WAIT_ICW3 restarts to WAIT_ICW2 and clears the mask.
- reset_n pulsed low during WAIT_ICW4 -> all outputs at reset values asynchronously. With CWD_POLL_COMMAND_EN defined, OCW3=0Ch sets poll_command, and one read cycle clears it.
